// File: rtl/draw_rect_ctl_pkg.sv
// draw_rect_ctl_pkg
// Shared types and constants for the bouncing-rectangle controller:
// motion state enum, rectangle/screen geometry and a saturating subtract.
package draw_rect_ctl_pkg;

    localparam int RECT_WIDTH  = 48;
    localparam int RECT_HEIGHT = 64;
    localparam int H           = 1024;
    localparam int V           = 768;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        RISE   = 2'd2,
        REST   = 2'd3
    } state_t;

    // a - b, clamped at zero instead of wrapping.
    function automatic logic [11:0] sat0_sub(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? (a - b) : 12'd0;
    endfunction

endpackage

// File: rtl/draw_rect_ctl_tick_gen.sv
// tick_gen
// Free-running counter 0..TICK_CYCLES-1; tick is high for the one cycle
// in which the count sits at TICK_CYCLES-1, after which it wraps to 0.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (count -> 0)
//   tick - one-cycle motion-update strobe
module tick_gen #(
    parameter int TICK_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl
// Positions a rectangle: follows the mouse until a left click, then drops it
// under gravity, bouncing off BOTTOM_Y with 3/4 of the impact speed until the
// impact speed is too small, where it rests until the next click.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   mouse_left         - left button level (synchronous to clk)
//   mouse_xpos/ypos    - mouse position, pixels
//   xpos/ypos          - registered rectangle position for draw_rect
module draw_rect_ctl
    import draw_rect_ctl_pkg::*;
#(
    parameter int TICK_CYCLES  = 65000,
    parameter int GRAVITY      = 1,
    parameter int BOTTOM_Y     = 704,
    parameter int MIN_BOUNCE_V = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos
);

    localparam logic [11:0] G   = 12'(GRAVITY);
    localparam logic [11:0] BY  = 12'(BOTTOM_Y);
    localparam logic [11:0] MBV = 12'(MIN_BOUNCE_V);

    state_t      state, state_nxt;
    logic [11:0] v, v_nxt, xpos_nxt, ypos_nxt;
    logic        mouse_left_d, click, tick;

    logic [12:0] sum;       // 13 bits so ypos+v+G cannot wrap past the floor test
    logic [11:0] vi, bounce_v;
    logic        impact;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign click    = mouse_left & ~mouse_left_d;
    assign sum      = {1'b0, ypos} + {1'b0, v} + {1'b0, G};
    assign vi       = v + G;
    assign impact   = (sum >= {1'b0, BY});
    assign bounce_v = vi - (vi >> 2);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FOLLOW;
            xpos         <= '0;
            ypos         <= '0;
            v            <= '0;
            mouse_left_d <= 1'b0;
        end else begin
            state        <= state_nxt;
            xpos         <= xpos_nxt;
            ypos         <= ypos_nxt;
            v            <= v_nxt;
            mouse_left_d <= mouse_left;
        end
    end

    // Next-state
    always_comb begin
        state_nxt = state;
        case (state)
            FOLLOW: if (click) state_nxt = FALL;
            FALL:   if (tick && impact) state_nxt = (vi < MBV) ? REST : RISE;
            RISE:   if (tick && (v <= G)) state_nxt = FALL;
            REST:   if (click) state_nxt = FOLLOW;
            default: state_nxt = FOLLOW;
        endcase
    end

    // Datapath next values; everything holds unless the state's rule fires
    always_comb begin
        xpos_nxt = xpos;
        ypos_nxt = ypos;
        v_nxt    = v;
        case (state)
            FOLLOW: begin
                xpos_nxt = mouse_xpos;
                ypos_nxt = (mouse_ypos > BY) ? BY : mouse_ypos;
                v_nxt    = '0;
            end
            FALL: if (tick) begin
                if (impact) begin
                    ypos_nxt = BY;
                    v_nxt    = (vi < MBV) ? 12'd0 : bounce_v;
                end else begin
                    ypos_nxt = sum[11:0];
                    v_nxt    = vi;
                end
            end
            RISE: if (tick) begin
                if (v <= G) begin
                    v_nxt = '0;
                end else begin
                    ypos_nxt = sat0_sub(ypos, v);
                    v_nxt    = v - G;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb_draw_rect_ctl
// Directed bench for draw_rect_ctl with TICK_CYCLES=4, GRAVITY=1,
// BOTTOM_Y=704, MIN_BOUNCE_V=2. Expected positions are hand-computed.
module tb_draw_rect_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [11:0] xpos, ypos;

    int nvec = 0;
    int nerr = 0;
    int tcnt = 0;
    int ticks = 0;

    draw_rect_ctl #(
        .TICK_CYCLES (4),
        .GRAVITY     (1),
        .BOTTOM_Y    (704),
        .MIN_BOUNCE_V(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos)
    );

    always #5 clk = ~clk;

    // Bench-side model of the 4-cycle tick timing
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else if (tcnt == 3) begin
            tcnt  <= 0;
            ticks <= ticks + 1;
        end else tcnt <= tcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance until just after the next tick edge (bounded)
    task automatic wait_tick();
        int t0;
        bit seen;
        t0   = ticks;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ticks != t0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL tick_timeout: got no tick expected tick within 8 cycles");
        end
    endtask

    logic [11:0] bounce_exp [0:21];

    initial begin
        // Drop from 690: fall, bounce (vi=5 -> v=4), rise, fall again,
        // bounce (vi=4 -> v=3), rise, then the start of the next fall.
        bounce_exp = '{691, 693, 696, 700, 704, 700, 697, 695,
                       695, 696, 698, 701, 704, 701, 699,
                       699, 700, 702, 704, 701, 699, 699};

        // Reset with mouse at (100,200)
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd200;
        rst = 1'b1;
        step();
        step();
        chk("rst_xpos", xpos, 12'd0);
        chk("rst_ypos", ypos, 12'd0);
        rst = 1'b0;
        step();
        chk("follow_xpos", xpos, 12'd100);
        chk("follow_ypos", ypos, 12'd200);

        // Clamp to BOTTOM_Y
        mouse_xpos = 12'd120;
        mouse_ypos = 12'd750;
        step();
        chk("clamp_xpos", xpos, 12'd120);
        chk("clamp_ypos", ypos, 12'd704);

        // Exactly at the floor is not clamped further
        mouse_ypos = 12'd704;
        step();
        chk("floor_ypos", ypos, 12'd704);

        // Click at 690
        mouse_xpos = 12'd130;
        mouse_ypos = 12'd690;
        step();
        mouse_left = 1'b1;
        step();
        chk("click_xpos", xpos, 12'd130);
        chk("click_ypos", ypos, 12'd690);
        mouse_xpos = 12'd500;
        mouse_ypos = 12'd10;

        for (int k = 0; k < 22; k++) begin
            wait_tick();
            chk($sformatf("bounce_ypos[%0d]", k), ypos, bounce_exp[k]);
            chk($sformatf("bounce_xpos[%0d]", k), xpos, 12'd130);
            // Between ticks: hold, and fresh clicks are ignored
            mouse_left = 1'b0;
            step();
            chk($sformatf("hold_ypos[%0d]", k), ypos, bounce_exp[k]);
            mouse_left = 1'b1;
            step();
            chk($sformatf("ignclick_xpos[%0d]", k), xpos, 12'd130);
        end

        // State now FALL (699, v=0); one tick more then reset mid-fall
        wait_tick();
        chk("prerst_ypos", ypos, 12'd700);
        mouse_left = 1'b0;
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd100;
        rst = 1'b1;
        step();
        chk("midrst_xpos", xpos, 12'd0);
        chk("midrst_ypos", ypos, 12'd0);
        rst = 1'b0;
        step();
        chk("postrst_xpos", xpos, 12'd300);
        chk("postrst_ypos", ypos, 12'd100);
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            chk($sformatf("noresume_ypos[%0d]", k), ypos, 12'd100);
        end

        // Click at 703: single tick lands on floor with vi=1 -> REST
        mouse_xpos = 12'd140;
        mouse_ypos = 12'd703;
        step();
        mouse_left = 1'b1;
        step();
        chk("click2_ypos", ypos, 12'd703);
        mouse_xpos = 12'd600;
        mouse_ypos = 12'd50;
        wait_tick();
        chk("land_ypos", ypos, 12'd704);
        for (int k = 0; k < 20; k++) begin
            wait_tick();
            chk($sformatf("rest_ypos[%0d]", k), ypos, 12'd704);
        end
        chk("rest_xpos", xpos, 12'd140);

        // Click in REST: outputs hold on the click edge, track mouse after
        mouse_left = 1'b0;
        step();
        mouse_left = 1'b1;
        step();
        chk("restclick_xpos", xpos, 12'd140);
        chk("restclick_ypos", ypos, 12'd704);
        step();
        chk("refollow_xpos", xpos, 12'd600);
        chk("refollow_ypos", ypos, 12'd50);
        mouse_ypos = 12'd800;
        step();
        chk("refollow_clamp", ypos, 12'd704);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
